// File: rtl/mem_resp.sv
// Memory-response stage: holds one instruction from the request stage, waits for its
// data-cache response, shapes load data and hands the result to write-back.
module mem_resp #(
  parameter  int MAX_PENDING = 2,
  localparam int CW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          pms_to_ms_valid,
  output logic          ms_allowin,
  input  logic          pms_req_sent,
  input  logic          pms_res_from_mem,
  input  logic [6:0]    pms_load_op,
  input  logic [1:0]    pms_addr_lo,
  input  logic [31:0]   pms_rt_value,
  input  logic [31:0]   pms_alu_result,
  input  logic [4:0]    pms_dest,
  input  logic [31:0]   pms_pc,
  input  logic          pms_ex,
  input  logic          data_data_ok,
  input  logic [31:0]   data_rdata,
  output logic          ms_to_ws_valid,
  input  logic          ws_allowin,
  output logic [31:0]   ms_result,
  output logic [4:0]    ms_dest,
  output logic [31:0]   ms_pc,
  output logic          ms_ex,
  output logic [1:0]    dbg_state,
  output logic [CW-1:0] dbg_discard_cnt
);

  // Handshake: an upstream transfer happens on a cycle where pms_to_ms_valid and
  // ms_allowin are both high and flush is low; a downstream transfer happens on a
  // cycle where ms_to_ws_valid and ws_allowin are both high. Neither valid waits on
  // the ready of its own channel.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [6:0] OP_LB  = 7'b0000001;
  localparam logic [6:0] OP_LBU = 7'b0000010;
  localparam logic [6:0] OP_LH  = 7'b0000100;
  localparam logic [6:0] OP_LHU = 7'b0001000;
  localparam logic [6:0] OP_LW  = 7'b0010000;
  localparam logic [6:0] OP_LWL = 7'b0100000;
  localparam logic [6:0] OP_LWR = 7'b1000000;

  state_e        state_q, state_d;
  logic [CW-1:0] discard_cnt_q, discard_cnt_d;

  logic          req_sent_q, req_sent_d;
  logic          res_from_mem_q, res_from_mem_d;
  logic [6:0]    load_op_q, load_op_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [31:0]   rt_value_q, rt_value_d;
  logic [31:0]   alu_result_q, alu_result_d;
  logic [4:0]    dest_q, dest_d;
  logic [31:0]   pc_q, pc_d;
  logic          ex_q, ex_d;
  logic [31:0]   rdata_q, rdata_d;

  logic accept;
  logic cnt_zero;
  logic rsp_drop;
  logic rsp_take;
  logic flush_inc;

  assign ms_allowin     = (state_q == S_IDLE) | ((state_q == S_HOLD) & ws_allowin);
  assign ms_to_ws_valid = (state_q == S_HOLD);
  assign accept         = pms_to_ms_valid & ms_allowin & ~flush;

  assign cnt_zero  = (discard_cnt_q == '0);
  assign rsp_drop  = data_data_ok & ~cnt_zero;
  assign rsp_take  = data_data_ok & cnt_zero & (state_q == S_WAIT) & ~flush;
  // A flushed WAIT still owes a response unless it arrives in the flush cycle itself.
  assign flush_inc = flush & (state_q == S_WAIT) & ~(data_data_ok & cnt_zero);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) state_d = (pms_req_sent & ~pms_ex) ? S_WAIT : S_HOLD;
        end
        S_WAIT: begin
          if (rsp_take) state_d = S_HOLD;
        end
        S_HOLD: begin
          if (ws_allowin) begin
            if (accept) state_d = (pms_req_sent & ~pms_ex) ? S_WAIT : S_HOLD;
            else        state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    discard_cnt_d = discard_cnt_q;
    if (flush_inc & ~rsp_drop) begin
      if (discard_cnt_q != CW'(MAX_PENDING)) discard_cnt_d = discard_cnt_q + CW'(1);
    end else if (rsp_drop & ~flush_inc) begin
      discard_cnt_d = discard_cnt_q - CW'(1);
    end
  end

  always_comb begin
    req_sent_d     = req_sent_q;
    res_from_mem_d = res_from_mem_q;
    load_op_d      = load_op_q;
    addr_lo_d      = addr_lo_q;
    rt_value_d     = rt_value_q;
    alu_result_d   = alu_result_q;
    dest_d         = dest_q;
    pc_d           = pc_q;
    ex_d           = ex_q;
    rdata_d        = rdata_q;
    if (accept) begin
      req_sent_d     = pms_req_sent;
      res_from_mem_d = pms_res_from_mem;
      load_op_d      = pms_load_op;
      addr_lo_d      = pms_addr_lo;
      rt_value_d     = pms_rt_value;
      alu_result_d   = pms_alu_result;
      dest_d         = pms_dest;
      pc_d           = pms_pc;
      ex_d           = pms_ex;
    end
    if (rsp_take) rdata_d = data_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      discard_cnt_q  <= '0;
      req_sent_q     <= 1'b0;
      res_from_mem_q <= 1'b0;
      load_op_q      <= '0;
      addr_lo_q      <= '0;
      rt_value_q     <= '0;
      alu_result_q   <= '0;
      dest_q         <= '0;
      pc_q           <= '0;
      ex_q           <= 1'b0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      discard_cnt_q  <= discard_cnt_d;
      req_sent_q     <= req_sent_d;
      res_from_mem_q <= res_from_mem_d;
      load_op_q      <= load_op_d;
      addr_lo_q      <= addr_lo_d;
      rt_value_q     <= rt_value_d;
      alu_result_q   <= alu_result_d;
      dest_q         <= dest_d;
      pc_q           <= pc_d;
      ex_q           <= ex_d;
      rdata_q        <= rdata_d;
    end
  end

  // Load data shaping works only from captured registers, so nothing is forwarded.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_q[7:0];
    unique case (addr_lo_q)
      2'd0: byte_sel = rdata_q[7:0];
      2'd1: byte_sel = rdata_q[15:8];
      2'd2: byte_sel = rdata_q[23:16];
      2'd3: byte_sel = rdata_q[31:24];
      default: byte_sel = rdata_q[7:0];
    endcase
    half_sel = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  always_comb begin
    ms_result = alu_result_q;
    if (res_from_mem_q) begin
      case (load_op_q)
        OP_LB:  ms_result = {{24{byte_sel[7]}}, byte_sel};
        OP_LBU: ms_result = {24'b0, byte_sel};
        OP_LH:  ms_result = {{16{half_sel[15]}}, half_sel};
        OP_LHU: ms_result = {16'b0, half_sel};
        OP_LW:  ms_result = rdata_q;
        OP_LWL: begin
          unique case (addr_lo_q)
            2'd0: ms_result = {rdata_q[7:0],  rt_value_q[23:0]};
            2'd1: ms_result = {rdata_q[15:0], rt_value_q[15:0]};
            2'd2: ms_result = {rdata_q[23:0], rt_value_q[7:0]};
            default: ms_result = rdata_q;
          endcase
        end
        OP_LWR: begin
          unique case (addr_lo_q)
            2'd0: ms_result = rdata_q;
            2'd1: ms_result = {rt_value_q[31:24], rdata_q[31:8]};
            2'd2: ms_result = {rt_value_q[31:16], rdata_q[31:16]};
            default: ms_result = {rt_value_q[31:8], rdata_q[31:24]};
          endcase
        end
        default: ms_result = rdata_q;
      endcase
    end
  end

  // Stores and excepting instructions never write a register.
  assign ms_dest         = (ex_q | (req_sent_q & ~res_from_mem_q)) ? 5'd0 : dest_q;
  assign ms_pc           = pc_q;
  assign ms_ex           = ex_q;
  assign dbg_state       = state_q;
  assign dbg_discard_cnt = discard_cnt_q;

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Pipeline stage directly downstream of the memory-request stage.
- Captures each instruction that stage issues and waits for the data-SRAM/cache response (data_ok) of any load/store it issued.
- Aligns, extends and merges load data (LB/LBU/LH/LHU/LW/LWL/LWR) and hands the result to write-back over a valid/allowin handshake.
- Drops responses belonging to instructions killed by an exception flush.

Parameters:
- MAX_PENDING, 2, maximum number of in-flight responses to discard after a flush; discard counter width is clog2(MAX_PENDING+1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  exception/ERET flush; kills the held instruction
- pms_to_ms_valid  in  1  upstream instruction valid
- ms_allowin  out  1  stage can accept an upstream instruction this cycle
- pms_req_sent  in  1  upstream issued a data request for this instruction (load or store accepted by cache)
- pms_res_from_mem  in  1  instruction is a load
- pms_load_op  in  7  one-hot {lwr,lwl,lw,lhu,lh,lbu,lb}, bit0=lb
- pms_addr_lo  in  2  unaligned address bits [1:0]
- pms_rt_value  in  32  old rt value for LWL/LWR merge
- pms_alu_result  in  32  non-load result
- pms_dest  in  5  destination register (0 = none)
- pms_pc  in  32  instruction PC
- pms_ex  in  1  instruction carries an exception (no request sent)
- data_data_ok  in  1  response pulse from data cache
- data_rdata  in  32  naturally aligned word containing the address
- ms_to_ws_valid  out  1  result valid to write-back
- ws_allowin  in  1  write-back accepts
- ms_result  out  32  final register write data
- ms_dest  out  5  destination (0 when ex)
- ms_pc  out  32  PC
- ms_ex  out  1  exception passthrough

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, discard_cnt 0, all outputs 0, except ms_allowin, which is 1.
- FSM states: IDLE (empty), WAIT (request outstanding), HOLD (data captured or no request needed).
- Accept when pms_to_ms_valid & ms_allowin:
  - Latch all pms_* fields.
  - Go to WAIT if pms_req_sent & ~pms_ex; otherwise HOLD.
- WAIT:
  - data_data_ok with discard_cnt==0: latch data_rdata, go to HOLD.
  - Data is never forwarded combinationally; it appears one cycle after data_ok.
- data_ok with discard_cnt>0: decrement discard_cnt, drop the data, state unchanged.
- Handshake:
  - ms_to_ws_valid = (state==HOLD).
  - ms_allowin = (state==IDLE) | (state==HOLD & ws_allowin).
  - On handoff, go to IDLE, or directly to the next state if accepting a new instruction the same cycle (back-to-back, no bubble).
- flush (highest priority):
  - State forces to IDLE and ms_to_ws_valid drops next cycle.
  - If state was WAIT and data_ok is not asserted that cycle, discard_cnt increments (saturates at MAX_PENDING).
  - Simultaneous flush and upstream valid: the upstream instruction is not accepted.
- ms_result:
  - Non-load: alu_result.
  - LB/LBU: byte at addr_lo, sign- or zero-extended.
  - LH/LHU: halfword rdata[16*addr_lo[1]+:16], extended.
  - LW: rdata.
  - LWL, addr 0/1/2/3: {rdata[7:0],rt[23:0]} / {rdata[15:0],rt[15:0]} / {rdata[23:0],rt[7:0]} / rdata.
  - LWR, addr 0/1/2/3: rdata / {rt[31:24],rdata[31:8]} / {rt[31:16],rdata[31:16]} / {rt[31:8],rdata[31:24]}.
- ms_ex=1: ms_dest forced 0, ms_result don't-care.
- Reset mid-WAIT: all state cleared. A late data_ok after reset is ignored, since state is IDLE and discard_cnt is 0.
- Stores: sent with pms_req_sent=1. They wait for data_ok like loads and produce ms_dest 0.

Test Plan:
- LB at addr_lo=3, rdata=0x80FF_1234 -> one cycle after data_ok: ms_to_ws_valid=1, ms_result=0xFFFF_FF80; LBU same -> 0x0000_0080.
- LWL addr_lo=1, rdata=0xAABBCCDD, rt=0x11223344 -> 0xCCDD3344; LWR addr_lo=2 same inputs -> 0x1122AABB.
- ws_allowin=0 for 3 cycles after capture -> result and ms_to_ws_valid held stable, ms_allowin=0; ws_allowin=1 with a new upstream load present -> handoff and accept in the same cycle.
- Flush in WAIT, data_ok 2 cycles later with 0xDEADBEEF -> discard_cnt 1->0, no valid output; next load's data_ok delivers its own data correctly.
- pms_ex=1 load accepted -> HOLD next cycle without data_ok, ms_ex=1, ms_dest=0; resetn pulsed low during WAIT -> outputs zero immediately (asynchronous), ms_allowin=1.
- Flush coincident with data_ok in WAIT -> data dropped, discard_cnt stays 0, state IDLE.
